// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed multichannel FIR:
// state encoding, width derivation and the output round/saturate step.
package fir_pkg;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_MAC,
      ST_ROUND,
      ST_OUT
   } fir_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Headroom of clog2(TAPS) bits keeps a full-scale sum of TAPS products in range.
   function automatic int acc_width(input int dw, input int cw, input int taps);
      return dw + cw + clog2(taps);
   endfunction

   // Drop CW-1 fraction bits with round-half-up, then clamp to the DW-bit range.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                    input int cw, input int dw);
      logic signed [64:0] r;
      logic signed [64:0] lim;
      r   = ($signed({acc[63], acc}) + (65'sd1 <<< (cw - 2))) >>> (cw - 1);
      lim = 65'sd1 <<< (dw - 1);
      if (r > lim - 65'sd1) r = lim - 65'sd1;
      else if (r < -lim)   r = -lim;
      return r[63:0];
   endfunction

endpackage

// File: rtl/fir_dpram.sv
// Simple dual-port RAM: one write port, one read port with registered data (1-cycle read).
// No reset on contents; no flow control.
module fir_dpram #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fir_mac_multich.sv
// Multichannel FIR, one shared multiplier/accumulator, one tap per cycle; dout_valid TAPS+4 cycles after accept.
// No backpressure: samples or coefficient writes arriving while busy are discarded and flagged on drop.
module fir_mac_multich
   import fir_pkg::*;
#(
   parameter int DW   = 24,
   parameter int CW   = 18,
   parameter int TAPS = 32,
   parameter int NCH  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH-1:0]         din_valid,
   input  logic [DW-1:0]          din,
   input  logic                   coef_we,
   input  logic [clog2(TAPS)-1:0] coef_addr,
   input  logic [CW-1:0]          coef_din,
   output logic [NCH-1:0]         dout_valid,
   output logic [DW-1:0]          dout,
   output logic                   busy,
   output logic                   drop
);
   localparam int LT  = clog2(TAPS);
   localparam int CHW = (NCH > 1) ? clog2(NCH) : 1;
   localparam int AW  = acc_width(DW, CW, TAPS);
   localparam int PW  = DW + CW;

   fir_state_e state_q, state_d;
   logic [LT-1:0]  cnt_q, cnt_d;
   logic [CHW-1:0] ch_q, ch_d;
   logic [LT-1:0]  rp_q, rp_d;
   logic [LT-1:0]  wptr_q [NCH];
   logic [LT-1:0]  wptr_d [NCH];
   logic           drop_q, drop_d, busy_q, busy_d;
   logic           v1_q, v1_d, v2_q, v2_d, f1_q, f1_d, f2_q, f2_d;
   logic [2:0]     tail_q, tail_d;
   logic signed [PW-1:0] prod_q, prod_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic [DW-1:0]  res_q, res_d, dout_q, dout_d;
   logic [CHW-1:0] res_ch_q, res_ch_d;
   logic [NCH-1:0] dv_q, dv_d;

   logic [CHW-1:0] sel_ch;
   logic           multi;
   logic           dl_we, cf_we;
   logic [CHW+LT-1:0] dl_waddr;
   logic [DW-1:0]  dl_wdata, x_rd;
   logic [CW-1:0]  c_rd;
   logic signed [63:0] rs;

   always_comb begin
      sel_ch = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (din_valid[k]) sel_ch = CHW'(k);
      end
   end

   assign multi = |(din_valid & (din_valid - NCH'(1)));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ch_d     = ch_q;
      rp_d     = rp_q;
      wptr_d   = wptr_q;
      drop_d   = drop_q;
      dl_we    = 1'b0;
      dl_waddr = {ch_q, cnt_q};
      dl_wdata = '0;
      cf_we    = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            dl_we = 1'b1;
            cnt_d = cnt_q + LT'(1);
            if (cnt_q == LT'(TAPS - 1)) begin
               cnt_d = '0;
               ch_d  = ch_q + CHW'(1);
               if (ch_q == CHW'(NCH - 1)) begin
                  ch_d    = '0;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_IDLE: begin
            cf_we = coef_we;
            if (|din_valid) begin
               dl_we          = 1'b1;
               dl_waddr       = {sel_ch, wptr_q[sel_ch]};
               dl_wdata       = din;
               ch_d           = sel_ch;
               rp_d           = wptr_q[sel_ch];
               cnt_d          = '0;
               wptr_d[sel_ch] = (wptr_q[sel_ch] == LT'(TAPS - 1)) ? '0 : wptr_q[sel_ch] + LT'(1);
               if (multi) drop_d = 1'b1;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            // Walk the delay line backwards from the newest sample while the tap index climbs.
            rp_d  = (rp_q == '0) ? LT'(TAPS - 1) : rp_q - LT'(1);
            cnt_d = cnt_q + LT'(1);
            if (cnt_q == LT'(TAPS - 1)) begin
               cnt_d   = '0;
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: state_d = ST_OUT;
         ST_OUT:   state_d = ST_IDLE;
         default:  state_d = ST_CLEAR;
      endcase
      if (state_q != ST_IDLE && (|din_valid || coef_we)) drop_d = 1'b1;
      busy_d = (state_d != ST_IDLE);
   end

   fir_dpram #(.ADDR_W(CHW + LT), .DATA_W(DW)) u_dline (
      .clk   (clk),
      .we    (dl_we & ~rst),
      .waddr (dl_waddr),
      .wdata (dl_wdata),
      .raddr ({ch_q, rp_q}),
      .rdata (x_rd)
   );

   fir_dpram #(.ADDR_W(LT), .DATA_W(CW)) u_coef (
      .clk   (clk),
      .we    (cf_we & ~rst),
      .waddr (coef_addr),
      .wdata (coef_din),
      .raddr (cnt_q),
      .rdata (c_rd)
   );

   assign rs = round_sat(64'(acc_q), CW, DW);

   // Datapath is two stages deep (RAM read, product register), so the ROUND/OUT
   // actions trail their FSM states by two cycles via tail_q.
   always_comb begin
      v1_d     = (state_q == ST_MAC);
      f1_d     = (cnt_q == '0);
      v2_d     = v1_q;
      f2_d     = f1_q;
      prod_d   = $signed(x_rd) * $signed(c_rd);
      acc_d    = acc_q;
      if (v2_q) acc_d = f2_q ? AW'(prod_q) : acc_q + AW'(prod_q);
      tail_d   = {tail_q[1:0], state_q == ST_ROUND};
      res_d    = res_q;
      res_ch_d = res_ch_q;
      if (tail_q[1]) begin
         res_d    = rs[DW-1:0];
         res_ch_d = ch_q;
      end
      dout_d = dout_q;
      dv_d   = '0;
      if (tail_q[2]) begin
         dout_d = res_q;
         dv_d   = NCH'(1) << res_ch_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         ch_q    <= '0;
         rp_q    <= '0;
         for (int k = 0; k < NCH; k++) wptr_q[k] <= '0;
         drop_q  <= 1'b0;
         busy_q  <= 1'b1;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         tail_q  <= '0;
         dout_q  <= '0;
         dv_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         rp_q    <= rp_d;
         wptr_q  <= wptr_d;
         drop_q  <= drop_d;
         busy_q  <= busy_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         tail_q  <= tail_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
      end
   end

   always_ff @(posedge clk) begin
      f1_q     <= f1_d;
      f2_q     <= f2_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      res_ch_q <= res_ch_d;
   end

   assign dout_valid = dv_q;
   assign dout       = dout_q;
   assign busy       = busy_q;
   assign drop       = drop_q;

endmodule
